// File: rtl/mult_issue_queue.sv
// mult_issue_queue
//   Issue stage in front of the pipelined 64-bit multiplier. Requests are
//   buffered in a small circular queue. At most one request per cycle is issued
//   to the multiplier from registered operands. An in-order tag FIFO pairs each
//   returning product with the tag of the request that produced it.
//   Optional statistics outputs (issue_count, stall_count) are compiled in
//   when the macro MULT_ISSUE_STATS_EN is defined.
module mult_issue_queue #(
    parameter int DEPTH    = 4,
    parameter int TAG_W    = 4,
    parameter int MULT_LAT = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [63:0]      req_mcand,
    input  logic [63:0]      req_mplier,
    input  logic [TAG_W-1:0] req_tag,
    output logic             mult_start,
    output logic [63:0]      mult_mcand,
    output logic [63:0]      mult_mplier,
    input  logic             mult_done,
    input  logic [63:0]      mult_product,
    output logic             resp_valid,
    output logic [63:0]      resp_product,
    output logic [TAG_W-1:0] resp_tag,
    output logic             err
`ifdef MULT_ISSUE_STATS_EN
    ,
    output logic [31:0]      issue_count,
    output logic [31:0]      stall_count
`endif
);

    localparam int AW   = $clog2(DEPTH);
    localparam int IFD  = MULT_LAT + 1;
    localparam int IFW  = (IFD > 1) ? $clog2(IFD) : 1;
    localparam int IFCW = $clog2(IFD + 1);

    localparam logic [IFW-1:0]  IF_LAST = IFW'(IFD - 1);
    localparam logic [IFCW-1:0] IF_FULL = IFCW'(IFD);

    // The in-flight FIFO depth is generally not a power of two, so its
    // indices wrap explicitly.
    function automatic logic [IFW-1:0] if_next(input logic [IFW-1:0] idx);
        return (idx == IF_LAST) ? '0 : idx + 1'b1;
    endfunction

`ifdef MULT_ISSUE_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] val);
        return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
    endfunction
`endif

    // Request queue: payload storage plus pointers with one extra wrap bit.
    logic [63:0]      r_q_mcand  [DEPTH];
    logic [63:0]      r_q_mplier [DEPTH];
    logic [TAG_W-1:0] r_q_tag    [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;

    // Registered multiplier interface.
    logic             r_start;
    logic [63:0]      r_mcand;
    logic [63:0]      r_mplier;

    // In-flight tag FIFO.
    logic [TAG_W-1:0] r_if_tag [IFD];
    logic [IFW-1:0]   r_if_wr;
    logic [IFW-1:0]   r_if_rd;
    logic [IFCW-1:0]  r_if_cnt;
    logic             r_err;

    logic [AW-1:0]    w_q_wr;
    logic [AW-1:0]    w_q_rd;
    logic             w_q_empty;
    logic             w_q_full;
    logic             w_if_empty;
    logic             w_if_full;
    logic             w_ready;
    logic             w_push;
    logic             w_issue;
    logic             w_if_pop;
    logic             w_stray_done;

    assign w_q_wr     = r_wptr[AW-1:0];
    assign w_q_rd     = r_rptr[AW-1:0];
    assign w_q_empty  = (r_wptr == r_rptr);
    assign w_q_full   = (r_wptr[AW] != r_rptr[AW]) && (w_q_wr == w_q_rd);
    assign w_if_empty = (r_if_cnt == '0);
    assign w_if_full  = (r_if_cnt == IF_FULL);

    // Readiness ignores a same-cycle pop, and flush blocks new requests.
    assign w_ready      = !w_q_full && !flush;
    assign w_push       = req_valid && w_ready;
    assign w_issue      = !w_q_empty && !w_if_full && !flush;
    assign w_if_pop     = mult_done && !w_if_empty;
    assign w_stray_done = mult_done && w_if_empty;

    // Queue pointers: flush collapses the queue; otherwise push and pop independently.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (flush) begin
            r_rptr <= r_wptr;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_issue)
                r_rptr <= r_rptr + 1'b1;
        end
    end

    // Queue payload storage; contents are only meaningful between the pointers.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_q_mcand[w_q_wr]  <= req_mcand;
            r_q_mplier[w_q_wr] <= req_mplier;
            r_q_tag[w_q_wr]    <= req_tag;
        end
    end

    // Issue register: start pulses for one cycle; operands hold between issues.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_start  <= 1'b0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else begin
            r_start <= w_issue;
            if (w_issue) begin
                r_mcand  <= r_q_mcand[w_q_rd];
                r_mplier <= r_q_mplier[w_q_rd];
            end
        end
    end

    // In-flight bookkeeping: push on issue, pop on done, and flag a stray done.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_if_wr  <= '0;
            r_if_rd  <= '0;
            r_if_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_issue)
                r_if_wr <= if_next(r_if_wr);
            if (w_if_pop)
                r_if_rd <= if_next(r_if_rd);
            case ({w_issue, w_if_pop})
                2'b10:   r_if_cnt <= r_if_cnt + 1'b1;
                2'b01:   r_if_cnt <= r_if_cnt - 1'b1;
                default: r_if_cnt <= r_if_cnt;
            endcase
            if (w_stray_done)
                r_err <= 1'b1;
        end
    end

    // In-flight tag storage, written with the tag of the request being issued.
    always_ff @(posedge clock) begin
        if (w_issue)
            r_if_tag[r_if_wr] <= r_q_tag[w_q_rd];
    end

`ifdef MULT_ISSUE_STATS_EN
    logic [31:0] r_issue_count;
    logic [31:0] r_stall_count;

    // Saturating statistics; stalls caused by flush are not counted.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_issue_count <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_issue)
                r_issue_count <= sat_inc(r_issue_count);
            if (req_valid && !w_ready && !flush)
                r_stall_count <= sat_inc(r_stall_count);
        end
    end

    assign issue_count = r_issue_count;
    assign stall_count = r_stall_count;
`endif

    assign req_ready    = w_ready;
    assign mult_start   = r_start;
    assign mult_mcand   = r_mcand;
    assign mult_mplier  = r_mplier;
    assign resp_valid   = mult_done;
    assign resp_product = mult_product;
    assign resp_tag     = w_if_empty ? '0 : r_if_tag[r_if_rd];
    assign err          = r_err;

endmodule

// File: doc/mult_issue_queue.md
Name: mult_issue_queue

Overview:
Issue stage directly upstream of the 8-stage pipelined 64-bit multiplier (mult).
- Buffers multiply requests arriving on a valid/ready interface.
- Drives the multiplier's start/mcand/mplier inputs from registers, at most one issue per cycle.
- Keeps an in-order tag FIFO for in-flight operations, so each product leaving the multiplier is returned with the requester's tag.

Parameters:
- DEPTH, 4, request queue entries (power of 2, ≥2).
- TAG_W, 4, request tag width.
- MULT_LAT, 8, cycles from mult_start high to mult_done high; in-flight tag FIFO holds MULT_LAT+1 entries.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous reset, active-low (0 = reset asserted).
- flush  in  1  synchronous clear of the request queue only.
- req_valid  in  1  request present.
- req_ready  out  1  queue can accept this cycle.
- req_mcand  in  64  multiplicand.
- req_mplier  in  64  multiplier.
- req_tag  in  TAG_W  requester tag.
- mult_start  out  1  registered; one-cycle issue pulse to mult start.
- mult_mcand  out  64  registered operand to mult.
- mult_mplier  out  64  registered operand to mult.
- mult_done  in  1  mult done.
- mult_product  in  64  mult product (low 64 bits).
- resp_valid  out  1  result valid; equals mult_done.
- resp_product  out  64  equals mult_product.
- resp_tag  out  TAG_W  tag at the head of the in-flight FIFO.
- err  out  1  sticky protocol error.

Behaviour:
Reset (reset=0, asynchronous):
- Queue and in-flight FIFO empty.
- req_ready=1, mult_start=0, mult_mcand=0, mult_mplier=0, resp_tag=0, err=0.
- Stats counters (if compiled in) = 0.

Request queue:
- Circular FIFO with DEPTH entries; read/write pointers are log2(DEPTH)+1 bits so wrap-around is detectable.
- req_ready = !full. It does not account for a same-cycle pop, so a full queue always stalls for one cycle.
- Push on req_valid && req_ready.

Issue:
- Each edge: if the queue is non-empty and the in-flight FIFO is not full, pop the head into mult_mcand/mult_mplier/tag and set mult_start=1.
- Otherwise mult_start=0; operands hold their last values.
- Latency: a request accepted at edge t, into an empty idle queue, produces mult_start=1 in the cycle after edge t+1.
- Back-to-back issue is allowed: one per cycle, operands change every cycle.

In-flight tag FIFO:
- Depth MULT_LAT+1.
- Push the issued tag at the same edge that sets mult_start.
- Pop on mult_done.
- Push and pop in the same edge leave occupancy unchanged.
- Issue is blocked while this FIFO is full.

Response (combinational):
- resp_valid=mult_done, resp_product=mult_product, resp_tag=head of the in-flight FIFO.
- The consumer has no backpressure; a response is valid for exactly one cycle.

Flush:
- Empties the request queue at the edge.
- A push in the same cycle is discarded; req_ready is forced 0 while flush=1.
- Issue is suppressed in a flush cycle.
- In-flight tags are unaffected; their results still return.

err:
- Set when mult_done=1 while the in-flight FIFO is empty.
- Sticky until reset; resp_tag=0 in that case.

Reset mid-operation:
- All state clears immediately.
- The multiplier shares the same reset, so no stale done is expected. A stale done after reset sets err.

Optional Feature:
Macro: MULT_ISSUE_STATS_EN
- Defined: adds outputs issue_count[31:0] and stall_count[31:0], both reset to 0.
  - issue_count increments per mult_start pulse.
  - stall_count increments per cycle with req_valid && !req_ready, flush cycles excluded.
  - Both counters saturate at 32'hFFFFFFFF.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single op: after reset, req mcand=3, mplier=5, tag=2 → mult_start one cycle later; mcand/mplier=3/5; 8 cycles later resp_valid=1, resp_product=15, resp_tag=2.
- Back-to-back: 4 requests (i+1)*(i+2), tags 0..3, in consecutive cycles → 4 consecutive mult_start pulses, responses 2, 6, 12, 20 with tags 0..3 in order.
- Full queue: hold mult idle by asserting req_valid for 6 cycles with no issue possible (in-flight FIFO prefilled to MULT_LAT+1) → req_ready=0 after 4 pushes, no push lost or duplicated once issue resumes.
- Flush: enqueue 3 requests, assert flush one cycle before the first issue → no mult_start; queue empty; req_ready=1 next cycle.
- Reset mid-operation: pull reset low with 2 in flight and 2 queued → outputs at reset values immediately; no resp_valid afterward; err=0.
- Protocol error: force mult_done=1 with nothing in flight → err=1 the next cycle and stays 1 until reset.
